// File: rtl/inst_mem_responder.sv
// Instruction-store responder: pipelined fetch port plus byte-serial loader.
// Ports: clock/reset, fetch (chipEnable, progCnter -> inst, instValid, instError), loader (loadEnable, loadByte, loadByteValid -> loadBusy, loadWrap, loadWordCount).
module inst_mem_responder #(
  parameter int INST_ADDR_WIDTH = 32,
  parameter int INST_WIDTH      = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int READ_LATENCY    = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       chipEnable,
  input  logic [INST_ADDR_WIDTH-1:0] progCnter,
  output logic [INST_WIDTH-1:0]      inst,
  output logic                       instValid,
  output logic                       instError,
  input  logic                       loadEnable,
  input  logic [7:0]                 loadByte,
  input  logic                       loadByteValid,
  output logic                       loadBusy,
  output logic                       loadWrap,
  output logic [$clog2(MEM_DEPTH_WORDS):0] loadWordCount
);

  localparam int IW = $clog2(MEM_DEPTH_WORDS);
  localparam int L  = READ_LATENCY;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [INST_WIDTH-1:0] mem [MEM_DEPTH_WORDS];

  // fetch decode
  logic [IW-1:0] fidx;
  logic          ferr;
  logic          facc;

  assign fidx = progCnter[IW+1:2];
  assign ferr = (progCnter[1:0] != 2'b00) ||
                ((progCnter >> (IW + 2)) != '0);
  assign facc = chipEnable && !loadBusy;

  // fetch pipeline; the store is read in stage 0
  logic [L-1:0]                 pv;
  logic [L-1:0]                 pe;
  logic [L-1:0][INST_WIDTH-1:0] pd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      pe <= '0;
      pd <= '0;
    end else begin
      pv[0] <= facc;
      pe[0] <= facc && ferr;
      pd[0] <= (facc && !ferr) ? mem[fidx] : '0;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign inst      = pd[L-1];
  assign instValid = pv[L-1];
  assign instError = pe[L-1];

  // loader FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // loader FSM: next state
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (loadEnable) state_nx = LOAD;
      LOAD:    if (!loadEnable) state_nx = FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // loader FSM: decoded controls
  logic enter;
  logic take;
  logic flush;

  always_comb begin
    enter = 1'b0;
    take  = 1'b0;
    flush = 1'b0;
    unique case (state)
      IDLE:    enter = loadEnable;
      LOAD:    take  = loadByteValid;
      FLUSH:   flush = 1'b1;
      default: ;
    endcase
  end

  // loader datapath
  logic [1:0]      bcnt;
  logic [IW-1:0]   wptr;
  logic [23:0]     part;
  logic            word_done;
  logic            flush_wr;
  logic            wen;
  logic [31:0]     word;

  assign word_done = take && (bcnt == 2'd3);
  assign flush_wr  = flush && (bcnt != 2'd0);
  assign wen       = word_done || flush_wr;
  // part keeps unfilled upper bytes at zero, so a flush pads them
  assign word      = word_done ? {loadByte, part} : {8'h00, part};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcnt          <= '0;
      wptr          <= '0;
      part          <= '0;
      loadBusy      <= 1'b0;
      loadWrap      <= 1'b0;
      loadWordCount <= '0;
    end else begin
      loadBusy <= (state_nx != IDLE);
      if (enter) begin
        bcnt          <= '0;
        wptr          <= '0;
        part          <= '0;
        loadWrap      <= 1'b0;
        loadWordCount <= '0;
      end
      if (take) begin
        if (bcnt == 2'd3) begin
          bcnt <= '0;
          part <= '0;
          wptr <= wptr + 1'b1;
          if (wptr == '1) loadWrap <= 1'b1;
        end else begin
          bcnt <= bcnt + 2'd1;
          case (bcnt)
            2'd0:    part[7:0]   <= loadByte;
            2'd1:    part[15:8]  <= loadByte;
            default: part[23:16] <= loadByte;
          endcase
        end
      end
      if (flush) begin
        bcnt <= '0;
        part <= '0;
      end
      if (wen && (loadWordCount != '1))
        loadWordCount <= loadWordCount + 1'b1;
    end
  end

  // store has no reset; writes only happen in LOAD/FLUSH
  always_ff @(posedge clock) begin
    if (wen) mem[wptr] <= INST_WIDTH'(word);
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Responder side of the instruction-fetch interface.
- Accepts the word address and chipEnable driven by the program-counter register, and returns the instruction word after a fixed, parameterised latency with a valid/error qualifier.
- Contains a byte-serial loader FSM that fills the instruction store before execution; reads are blocked while loading.
- Sits between the PC register and the decode stage.

Parameters:
INST_ADDR_WIDTH, 32, width of the fetch address
INST_WIDTH, 32, width of an instruction word
MEM_DEPTH_WORDS, 1024, number of words in the store (power of two, at least 4)
READ_LATENCY, 1, clock edges from address sample to data valid (1 to 4)

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
chipEnable  input  1  fetch request qualifier from the PC register
progCnter  input  INST_ADDR_WIDTH  byte address of the requested instruction
inst  output  INST_WIDTH  returned instruction word
instValid  output  1  inst/instError meaningful this cycle
instError  output  1  returned request was misaligned or out of range
loadEnable  input  1  level: loader session active
loadByte  input  8  program byte
loadByteValid  input  1  loadByte is to be consumed this cycle
loadBusy  output  1  loader FSM not IDLE; fetch requests are ignored
loadWrap  output  1  sticky: the write pointer wrapped past MEM_DEPTH_WORDS-1 in this session
loadWordCount  output  clog2(MEM_DEPTH_WORDS)+1  words written in the current session

Behaviour:
Reset
- While reset=0, all of the following are asynchronously cleared to 0: inst, instValid, instError, loadBusy, loadWrap, loadWordCount, the pipeline valid bits, the byte counter and the word pointer.
- FSM goes to IDLE.
- Store contents are not cleared.
- Reset asserted mid-load abandons any partial word; it is not written.

Fetch path
- A request is accepted at a rising edge when chipEnable=1 and loadBusy=0.
- Word index = progCnter[clog2(MEM_DEPTH_WORDS)+1 : 2].
- Error if progCnter[1:0] != 0, or if any progCnter bit above the index field is nonzero.
- After exactly READ_LATENCY edges: instValid=1.
  - If no error: inst = store[word index], instError=0.
  - If error: inst=0, instError=1.
- Throughput: one request per cycle, fully pipelined.
- Cycles with no accepted request produce a bubble: instValid=0, instError=0, inst=0 at the matching output cycle.
- Requests already in flight when loadBusy rises still complete. Their read data is the store content sampled at acceptance time (read occurs in the first pipeline stage).

Loader FSM (states IDLE, LOAD, FLUSH)
- IDLE -> LOAD when loadEnable=1. On entry: word pointer=0, byte counter=0, loadWordCount=0, loadWrap=0.
- In LOAD, each cycle with loadByteValid=1 shifts the byte in, little-endian: the first byte lands in bits 7:0, the fourth in bits 31:24.
- On the fourth byte:
  - the word is written to store[pointer] on that same edge;
  - the pointer increments modulo MEM_DEPTH_WORDS;
  - loadWordCount increments, saturating at its maximum;
  - if the pointer wraps from MEM_DEPTH_WORDS-1 to 0, loadWrap is set.
- LOAD -> FLUSH when loadEnable=0.
  - Any loadByteValid in that same cycle is still consumed.
- FLUSH lasts exactly one cycle, then goes to IDLE.
  - If the byte counter is nonzero, the partial word is written zero-padded in the upper bytes and loadWordCount increments.
  - If the byte counter is zero, nothing is written.
- loadEnable re-asserted while in FLUSH is ignored until IDLE; it is taken on the next edge after that.
- loadBusy=1 in LOAD and FLUSH, and is registered (asserts the cycle after IDLE->LOAD is taken).
- loadByteValid while in IDLE or FLUSH is ignored.
- loadWrap and loadWordCount hold their values in IDLE until the next session starts.

Test Plan:
- Load bytes 13,00,00,00, 93,00,10,00; drop loadEnable; fetch progCnter=0x0 then 0x4 with READ_LATENCY=1 -> inst=0x00000013 then 0x00100093 on consecutive cycles, instValid=1, instError=0, loadWordCount=2.
- Back-to-back fetches 0x0, 0x4, 0x8 with chipEnable low for one cycle between the 2nd and 3rd, READ_LATENCY=3 -> outputs arrive 3 edges after each request, with one instValid=0 bubble in the matching position.
- Fetch progCnter=0x6 -> instError=1, inst=0. Fetch progCnter=0x00001000 with MEM_DEPTH_WORDS=1024 -> instError=1.
- Load 5 bytes AA,BB,CC,DD,EE then drop loadEnable -> store[0]=0xDDCCBBAA, store[1]=0x000000EE after FLUSH, loadWordCount=2.
- MEM_DEPTH_WORDS=4: load 20 bytes -> loadWrap=1, store[0] holds word 5, loadWordCount=5. A fetch request during LOAD -> no instValid.
- Pull reset low mid-load after 2 bytes and mid-fetch pipeline -> all outputs 0 immediately, no partial write, FSM in IDLE, and the first fetch after reset release returns the pre-reset store content.
